// File: rtl/wb_arb2_if.sv
// Bus bundle for the two-master Wishbone arbiter: both master ports plus the shared slave port.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface wb_arb2_if;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o;

  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o;

  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter with a combinational data path and a
// per-tenure strobe watchdog that aborts a transfer the slave never acknowledges.
module wb_arb2 #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  wb_arb2_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       own_stb;
  logic       tmo_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (bus.m0_cyc_i)            state_d = GNT0;
        else if (bus.m1_cyc_i)            state_d = GNT1;
      end
      GNT0: if (!bus.m0_cyc_i) state_d = bus.m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!bus.m1_cyc_i) state_d = bus.m0_cyc_i ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
    if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;
  end

  assign own_stb = (state_q == GNT0 && bus.m0_stb_i) || (state_q == GNT1 && bus.m1_stb_i);
  // tmo_hit deliberately ignores s_ack_i so s_stb_o never depends on the slave's ack.
  assign tmo_hit = own_stb && (cnt_q == TIMEOUT);

  always_comb begin
    if (state_d != state_q || !own_stb || bus.s_ack_i || tmo_hit) cnt_d = 8'd0;
    else                                                          cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces IDLE asynchronously, which zeroes every output below.
  always_comb begin
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_adr_o  = 32'd0;
    bus.s_dat_o  = 32'd0;
    bus.s_sel_o  = 4'd0;
    bus.m0_dat_o = 32'd0;
    bus.m0_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m1_dat_o = 32'd0;
    bus.m1_ack_o = 1'b0;
    bus.m1_err_o = 1'b0;
    case (state_q)
      GNT0: begin
        bus.s_cyc_o  = bus.m0_cyc_i;
        bus.s_stb_o  = bus.m0_stb_i && !tmo_hit;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.m0_dat_o = bus.s_dat_i;
        bus.m0_ack_o = bus.s_ack_i;
        bus.m0_err_o = tmo_hit && !bus.s_ack_i;
      end
      GNT1: begin
        bus.s_cyc_o  = bus.m1_cyc_i;
        bus.s_stb_o  = bus.m1_stb_i && !tmo_hit;
        bus.s_we_o   = bus.m1_we_i;
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.m1_dat_o = bus.s_dat_i;
        bus.m1_ack_o = bus.s_ack_i;
        bus.m1_err_o = tmo_hit && !bus.s_ack_i;
      end
      default: ;
    endcase
  end

endmodule
